// File: rtl/host_wr_arb_pkg.sv
// host_wr_arb_pkg
// Shared constants and types for the host bridge FIFO write-port arbiter.
//   - requester index constants (GPS, RX, WF, EXT, MEM)
//   - NREQ, SPIBUF_W (FIFO depth in 16-bit words), LEN_W, DATA_W
//   - clog2() for sizing counters from parameters
//   - rr_next() wrap-around increment of a requester index
//   - arb_state_e, the arbiter FSM state encoding
package host_wr_arb_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int NREQ     = 5;
    localparam int SPIBUF_W = 2048;
    localparam int LEN_W    = 12;
    localparam int DATA_W   = 16;
    localparam int IDX_W    = clog2(NREQ);

    localparam int REQ_GPS = 0;
    localparam int REQ_RX  = 1;
    localparam int REQ_WF  = 2;
    localparam int REQ_EXT = 3;
    localparam int REQ_MEM = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // Next requester index after idx, wrapping NREQ-1 back to 0.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/host_wr_arb_if.sv
// host_wr_arb_if
// Source-side and FIFO-side bus of the host write arbiter.
//   req      : burst request, level, one bit per requester
//   req_len  : packed burst lengths (words), sampled at grant
//   req_data : packed source data words
//   gnt      : one-hot grant, held for the whole burst
//   rd_stb   : per-requester word pull, only on the granted bit
//   fifo_wr  : FIFO write strobe (== |rd_stb)
//   fifo_din : FIFO write data, 0 when not writing
// Handshake: a source raises req and keeps it high (and req_len stable) until
// it sees the burst finish; once granted the burst is committed. In every
// cycle rd_stb[i] is high the source must present its word on req_data[i]
// combinationally and treat that word as consumed at the next clock edge.
// There is no back-pressure toward the arbiter beyond its own full tracking.
// modport master is the arbiter view, slave is the sources/FIFO view.
interface host_wr_arb_if;
    import host_wr_arb_pkg::*;

    logic [NREQ-1:0]        req;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rd_stb;
    logic                   fifo_wr;
    logic [DATA_W-1:0]      fifo_din;

    modport master (
        input  req, req_len, req_data,
        output gnt, rd_stb, fifo_wr, fifo_din
    );

    modport slave (
        output req, req_len, req_data,
        input  gnt, rd_stb, fifo_wr, fifo_din
    );
endinterface

// File: rtl/host_wr_arb_rr_pick.sv
// host_wr_arb_rr_pick
// Combinational round-robin priority encoder: returns the first set request
// bit at or after ptr_i, wrapping past NREQ-1 back to 0.
//   req_i   : request vector
//   ptr_i   : search start index (0..NREQ-1)
//   valid_o : any request set
//   idx_o   : chosen index (0 when valid_o is low)
module host_wr_arb_rr_pick
    import host_wr_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_i} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(NREQ)) cand = cand - (IDX_W + 1)'(NREQ);
            if (req_i[cand[IDX_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/host_wr_arb.sv
// host_wr_arb
// Round-robin burst arbiter for the host bridge FIFO write port. One requester
// at a time is granted a committed burst of req_len words; the FIFO fill level
// is tracked here and writes stall while the FIFO is full.
//   hb_clk      : clock, rising edge
//   ha_rst      : asynchronous active-high reset
//   bus         : source/FIFO bus (master modport)
//   fifo_clr_i  : FIFO pointer reset; clears level, aborts an active burst
//   level_o     : words written since the last fifo_clr_i
//   full_o      : level_o == DEPTH
//   busy_o      : FSM not idle
//   done_o      : one-cycle pulse, burst completed normally
//   abort_o     : one-cycle pulse, burst killed by fifo_clr_i
//   dbg_state_o : current FSM state
module host_wr_arb
    import host_wr_arb_pkg::*;
#(
    parameter int DEPTH = SPIBUF_W
) (
    input  logic                  hb_clk,
    input  logic                  ha_rst,
    host_wr_arb_if.master         bus,
    input  logic                  fifo_clr_i,
    output logic [clog2(DEPTH):0] level_o,
    output logic                  full_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  abort_o,
    output arb_state_e            dbg_state_o
);

    localparam int LVL_BITS = clog2(DEPTH) + 1;

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [LVL_BITS-1:0] level_q, level_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             full;
    logic             wr;
    logic             abort;
    logic [NREQ-1:0]  idx_oh;

    host_wr_arb_rr_pick u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign full   = (level_q == LVL_BITS'(DEPTH));
    assign idx_oh = NREQ'(1) << idx_q;
    // A clear in the same cycle wins over the write so the word is not counted
    // against the freshly emptied FIFO.
    assign wr     = (state_q == ST_XFER) && !full && (rem_q != '0) && !fifo_clr_i;
    assign abort  = fifo_clr_i && ((state_q == ST_GRANT) || (state_q == ST_XFER));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        level_d = level_q;

        if (fifo_clr_i)  level_d = '0;
        else if (wr)     level_d = level_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    rem_d   = bus.req_len[pick_idx*LEN_W +: LEN_W];
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: state_d = (rem_q == '0) ? ST_DONE : ST_XFER;
            ST_XFER: begin
                if (wr) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_d   = rr_next(idx_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // An aborted requester still loses its turn so it cannot starve others.
        if (abort) begin
            state_d = ST_IDLE;
            ptr_d   = rr_next(idx_q);
        end
    end

    always_ff @(posedge hb_clk or posedge ha_rst) begin
        if (ha_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            level_q <= level_d;
        end
    end

    // Grant stays up through GRANT, XFER and the DONE cycle.
    assign bus.gnt      = (state_q != ST_IDLE) ? idx_oh : '0;
    assign bus.rd_stb   = wr ? idx_oh : '0;
    assign bus.fifo_wr  = wr;
    assign bus.fifo_din = wr ? bus.req_data[idx_q*DATA_W +: DATA_W] : '0;

    assign level_o     = level_q;
    assign full_o      = full;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign abort_o     = abort;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_host_wr_arb.sv
module tb_host_wr_arb;
    import host_wr_arb_pkg::*;

    localparam int DEPTH = SPIBUF_W;
    localparam int LW    = clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic hb_clk = 1'b0;
    logic ha_rst = 1'b1;
    logic fifo_clr = 1'b0;
    always #5 hb_clk = ~hb_clk;

    logic [LW-1:0] level;
    logic          full, busy, done, abort;
    arb_state_e    dbg_state;

    host_wr_arb_if bus();

    // ---------------- source model ----------------
    logic [LEN_W-1:0]       len_v [NREQ];
    logic [11:0]            cnt [NREQ];       // words consumed per source
    int                     issued [NREQ];    // bursts requested (driver)
    int                     done_cnt [NREQ];  // bursts finished (monitor)
    int                     exp_next [NREQ];  // next expected word index
    logic [NREQ-1:0]        req_v;
    logic [NREQ*16-1:0]     data_v;
    logic [NREQ*LEN_W-1:0]  len_flat;

    always_comb begin
        req_v    = '0;
        data_v   = '0;
        len_flat = '0;
        for (int s = 0; s < NREQ; s++) begin
            req_v[s]                 = (issued[s] > done_cnt[s]);
            data_v[s*16 +: 16]       = {4'(s + 1), cnt[s]};
            len_flat[s*LEN_W +: LEN_W] = len_v[s];
        end
    end

    assign bus.req      = req_v;
    assign bus.req_len  = len_flat;
    assign bus.req_data = data_v;

    host_wr_arb #(.DEPTH(DEPTH)) dut (
        .hb_clk      (hb_clk),
        .ha_rst      (ha_rst),
        .bus         (bus),
        .fifo_clr_i  (fifo_clr),
        .level_o     (level),
        .full_o      (full),
        .busy_o      (busy),
        .done_o      (done),
        .abort_o     (abort),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [20:0] exp_q[$];        // {rd_stb, fifo_din} per expected write
    logic [4:0]  exp_done_q[$];   // gnt at each expected done pulse
    logic [4:0]  exp_abort_q[$];  // gnt at each expected abort pulse

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] oh(input int s);
        return 5'(1) << s;
    endfunction

    function automatic logic [15:0] word(input int s, input int n);
        logic [11:0] c;
        c = n[11:0];
        return {4'(s + 1), c};
    endfunction

    // Monitor: compares every write, done and abort against the queues.
    always @(negedge hb_clk) begin
        if (!ha_rst) begin
            if (bus.fifo_wr) begin
                check("wr_vs_stb", 64'(bus.fifo_wr), 64'(|bus.rd_stb));
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {bus.rd_stb, bus.fifo_din}, 64'h0);
                end else begin
                    check("write", {bus.rd_stb, bus.fifo_din}, exp_q.pop_front());
                end
                for (int s = 0; s < NREQ; s++)
                    if (bus.rd_stb[s]) cnt[s] = cnt[s] + 1'b1;
            end else begin
                check("idle_bus", {bus.rd_stb, bus.fifo_din}, 64'h0);
            end
            if (done) begin
                if (exp_done_q.size() == 0) check("unexpected_done", bus.gnt, 64'h0);
                else check("done_gnt", bus.gnt, exp_done_q.pop_front());
                for (int s = 0; s < NREQ; s++)
                    if (bus.gnt[s]) done_cnt[s]++;
            end
            if (abort) begin
                if (exp_abort_q.size() == 0) check("unexpected_abort", bus.gnt, 64'h0);
                else check("abort_gnt", bus.gnt, exp_abort_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge hb_clk);
        #1;
    endtask

    task automatic start(input int s, input int len, input int bursts);
        len_v[s]  = LEN_W'(len);
        issued[s] = issued[s] + bursts;
    endtask

    task automatic cancel(input int s);
        issued[s] = done_cnt[s];
    endtask

    task automatic push_burst(input int s, input int n, input bit with_done);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({oh(s), word(s, exp_next[s])});
            exp_next[s]++;
        end
        if (with_done) exp_done_q.push_back(oh(s));
    endtask

    task automatic wait_quiet(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = (exp_q.size() == 0) && (exp_done_q.size() == 0) && !busy && (req_v == '0);
        end
        check(name, 64'(ok), 64'h1);
    endtask

    task automatic do_reset();
        ha_rst = 1'b1;
        fifo_clr = 1'b0;
        for (int s = 0; s < NREQ; s++) cancel(s);
        repeat (2) tick();
        ha_rst = 1'b0;
        tick();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [6:0] exp_row;
        bit ok;
        for (int s = 0; s < NREQ; s++) begin
            len_v[s] = '0; cnt[s] = '0; issued[s] = 0; done_cnt[s] = 0; exp_next[s] = 0;
        end

        // Reset state
        repeat (2) tick();
        check("rst_bus", {bus.gnt, bus.rd_stb, bus.fifo_wr, bus.fifo_din}, 64'h0);
        check("rst_status", {level, full, busy, done, abort}, 64'h0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        ha_rst = 1'b0;
        tick();

        // T1: req[1] len 4, cycle-accurate
        start(REQ_RX, 4, 1);
        push_burst(REQ_RX, 4, 1);
        @(negedge hb_clk);
        check("t1_c0", {bus.gnt, bus.fifo_wr, done}, 64'h0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge hb_clk);
            exp_row = {((c >= 1 && c <= 6) ? 5'b00010 : 5'b00000),
                       (c >= 2 && c <= 5), (c == 6)};
            check($sformatf("t1_c%0d", c), {bus.gnt, bus.fifo_wr, done}, 64'(exp_row));
        end
        wait_quiet(20, "t1_quiet");
        check("t1_level", level, 64'd4);

        // T1b: rr_ptr is now 2, so req {0,2} grants 2 before 0
        start(REQ_GPS, 1, 1);
        start(REQ_WF, 1, 1);
        push_burst(REQ_WF, 1, 1);
        push_burst(REQ_GPS, 1, 1);
        wait_quiet(40, "t1b_quiet");
        check("t1b_level", level, 64'd6);

        // T2: all requesting len 2 from reset -> order 0..4
        do_reset();
        for (int s = 0; s < NREQ; s++) start(s, 2, 1);
        for (int s = 0; s < NREQ; s++) push_burst(s, 2, 1);
        wait_quiet(100, "t2_quiet");
        check("t2_level", level, 64'd10);

        // T3: fill to DEPTH-2, then len 5 stalls after 2 words; clr aborts
        do_reset();
        start(REQ_RX, DEPTH - 2, 1);
        push_burst(REQ_RX, DEPTH - 2, 1);
        wait_quiet(DEPTH + 100, "t3_fill_quiet");
        check("t3_level_pre", level, 64'(DEPTH - 2));
        start(REQ_WF, 5, 1);
        push_burst(REQ_WF, 2, 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = full;
        end
        check("t3_full_seen", 64'(ok), 64'h1);
        check("t3_level_full", level, 64'(DEPTH));
        repeat (4) tick();
        check("t3_stall_state", 64'(dbg_state), 64'(ST_XFER));
        check("t3_stall_gnt", bus.gnt, 64'(oh(REQ_WF)));
        check("t3_stall_pending", 64'(exp_q.size()), 64'h0);
        fifo_clr = 1'b1;
        cancel(REQ_WF);
        exp_abort_q.push_back(oh(REQ_WF));
        #1;
        check("t3_clr_cycle", {abort, bus.fifo_wr}, 64'h2);
        tick();
        fifo_clr = 1'b0;
        check("t3_after_clr", {level, full, bus.gnt}, 64'h0);
        check("t3_after_state", 64'(dbg_state), 64'(ST_IDLE));

        // T3b: clr lands on a cycle that would have written -> suppressed
        start(REQ_GPS, 4, 1);
        push_burst(REQ_GPS, 2, 0);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = (exp_q.size() == 0);
        end
        check("t3b_two_words", 64'(ok), 64'h1);
        fifo_clr = 1'b1;
        cancel(REQ_GPS);
        exp_abort_q.push_back(oh(REQ_GPS));
        #1;
        check("t3b_clr_suppress", {abort, bus.fifo_wr, bus.rd_stb}, 64'h40);
        check("t3b_level_pre", level, 64'd2);
        tick();
        fifo_clr = 1'b0;
        check("t3b_level_post", level, 64'd0);
        check("t3b_state", 64'(dbg_state), 64'(ST_IDLE));

        // T4: len 0 -> gnt two cycles, done, no write
        start(REQ_EXT, 0, 1);
        exp_done_q.push_back(oh(REQ_EXT));
        @(negedge hb_clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge hb_clk);
            exp_row = {((c <= 2) ? 5'b01000 : 5'b00000), 1'b0, (c == 2)};
            check($sformatf("t4_c%0d", c), {bus.gnt, bus.fifo_wr, done}, 64'(exp_row));
        end
        wait_quiet(20, "t4_quiet");
        check("t4_level", level, 64'd0);

        // T5: req[0] held for two bursts, req[4] arrives mid-burst -> 0,4,0
        start(REQ_GPS, 3, 2);
        push_burst(REQ_GPS, 3, 1);
        push_burst(REQ_MEM, 2, 1);
        push_burst(REQ_GPS, 3, 1);
        repeat (3) tick();
        len_v[REQ_MEM] = LEN_W'(2);
        issued[REQ_MEM] = issued[REQ_MEM] + 1;
        wait_quiet(100, "t5_quiet");
        check("t5_level", level, 64'd8);

        // T6: async reset mid-burst, then a fresh burst
        start(REQ_MEM, 100, 1);
        push_burst(REQ_MEM, 100, 0);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = (exp_q.size() == 90);
        end
        check("t6_ten_words", 64'(ok), 64'h1);
        ha_rst = 1'b1;
        #1;
        check("t6_rst_bus", {bus.gnt, bus.rd_stb, bus.fifo_wr, bus.fifo_din}, 64'h0);
        check("t6_rst_status", {level, full, busy, done, abort}, 64'h0);
        check("t6_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        exp_next[REQ_MEM] = exp_next[REQ_MEM] - exp_q.size();
        exp_q.delete();
        do_reset();
        start(REQ_WF, 3, 1);
        push_burst(REQ_WF, 3, 1);
        wait_quiet(30, "t6_quiet");
        check("t6_level", level, 64'd3);

        check("final_queues", 64'(exp_q.size() + exp_done_q.size() + exp_abort_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/host_wr_arb.md
Name: host_wr_arb

Overview:
Round-robin burst arbiter that shares the host bridge FIFO write port (port B) among the data sources: GPS, RX, WF, EXT and MEM.
- Replaces fixed-priority MUXing of the per-source read strobes.
- Grants one requester at a time for a committed burst of N 16-bit words.
- Tracks FIFO fill level and stalls when full.
- Sits between the source blocks and the host FIFO, in the hb_clk domain.

Parameters:
NREQ, 5, number of requesters; index 0=GPS, 1=RX, 2=WF, 3=EXT, 4=MEM
DEPTH, 2048, FIFO capacity in 16-bit words (equals SPIBUF_W)
LEN_W, 12, width of the per-requester burst length

Ports:
hb_clk  in  1  clock; all logic on the rising edge
ha_rst  in  1  reset, asynchronous, active-high
req  in  NREQ  burst request, level, one bit per requester
req_len  in  NREQ*LEN_W  burst length in words, packed, sampled at grant
req_data  in  NREQ*16  source data words, packed
fifo_clr  in  1  FIFO pointer reset (host_rst | boot_rst)
gnt  out  NREQ  one-hot grant, held for the whole burst
rd_stb  out  NREQ  per-requester word pull; asserted only on the granted bit
fifo_wr  out  1  FIFO write strobe
fifo_din  out  16  write data
level  out  clog2(DEPTH)+1  words written since last fifo_clr
full  out  1  level == DEPTH
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a burst completes normally
abort  out  1  one-cycle pulse when fifo_clr kills an active burst

Behaviour:
- Reset values: state IDLE; gnt, rd_stb, fifo_wr, done, abort = 0; level = 0; full = 0; rr_ptr = 0.
- States:
  - IDLE: if any req bit is set, pick the first set bit searching from rr_ptr upward with wrap; latch idx, latch len=req_len[idx], set gnt; next state GRANT.
  - GRANT: one cycle of setup. If len==0, go to DONE; otherwise go to XFER.
  - XFER: each cycle with ~full and remaining>0, assert rd_stb[idx] and fifo_wr; decrement remaining, increment level. When the last word is written (remaining 1→0), go to DONE.
  - DONE: pulse done, drop gnt, set rr_ptr=(idx+1) mod NREQ, return to IDLE.
- Latency: req at cycle 0 → gnt at cycle 1 → first rd_stb/fifo_wr at cycle 2 → a burst of N words completes in N+3 cycles with no stall.
- fifo_wr == |rd_stb, same cycle. fifo_din is a combinational one-hot mux of req_data[idx]. Sources present their data combinationally in the rd_stb cycle.
- fifo_din = 0 when not writing.
- req is sampled only in IDLE. Dropping req mid-burst has no effect because the burst is committed.
- req staying high after done causes re-arbitration; another active requester wins first (round-robin fairness).
- Full: while level==DEPTH, rd_stb and fifo_wr stay 0 and the state holds in XFER. There is no write past full and no error.
- fifo_clr (synchronous, highest priority):
  - level←0, full←0.
  - If state is GRANT or XFER: abort pulse, gnt dropped, go to IDLE, rr_ptr advances past idx.
  - A write in the same cycle as fifo_clr is suppressed.
- level never wraps; width clog2(DEPTH)+1 holds DEPTH exactly.
- Simultaneous req on all bits: the grant order rotates 0,1,2,3,4,0…
- ha_rst asserted mid-burst: all outputs return to reset values immediately, asynchronously.

Decomposition:
- Shared package/include (kiwi.gen.vh): requester index constants (REQ_GPS…REQ_MEM), NREQ, SPIBUF_W, the clog2 function.
- One natural sub-module: rr_pick, a combinational round-robin priority encoder (req, rr_ptr → valid, idx). It is reusable by other arbiters.

Test Plan:
1. Single req[1] with len=4 from reset → gnt=00010 at cycle 1; rd_stb[1]/fifo_wr at cycles 2–5; done at cycle 6; level=4, rr_ptr=2.
2. req=11111, all len=2 → grant order 0,1,2,3,4; fifo_din matches each source; level=10; five done pulses.
3. level preloaded to DEPTH-2, req[2] len=5 → 2 writes, full=1, stall; fifo_clr → abort pulse, level=0, gnt=0, no write in the clr cycle.
4. req[3] len=0 → gnt for 2 cycles, no fifo_wr, done pulse, level unchanged.
5. req[0] held high with req[4] asserted during burst 0 → next grant goes to 4, then 0.
6. ha_rst asserted mid-XFER on len=100 → all outputs 0 within the same cycle; after release, IDLE, and a new burst works.
